// File: rtl/spi_host_pkg.sv
// Shared types for the SPI host master: word type, FSM states
// and the default word width. No ports.
package spi_host_pkg;
   localparam int SPI_WORD_W = 16;

   typedef logic [SPI_WORD_W-1:0] spi_word_t;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      NEXT,
      HOLD
   } spi_host_state_t;
endpackage

// File: rtl/spi_host_if.sv
// Word-level handshake between the SPI host master and its user.
// master: producer/consumer side; slave: the SPI host master.
interface spi_host_if
   import spi_host_pkg::*;
#(
   parameter int WORD_W = SPI_WORD_W
) ();
   logic [WORD_W-1:0] txData;
   logic              txRequest;
   logic              txDone;
   logic [WORD_W-1:0] rxData;
   logic              rxValid;
   logic              busy;

   modport master (
      output txData, txRequest,
      input  txDone, rxData, rxValid, busy
   );

   modport slave (
      input  txData, txRequest,
      output txDone, rxData, rxValid, busy
   );
endinterface

// File: rtl/spi_host_sck_gen.sv
// SCK divider: CLK_DIV cycles per half-period, rise/fall strobes.
// Ports: clk, rst (async low), en; outputs rise, fall, sck.
module spi_host_sck_gen
   import spi_host_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic rise,
   output logic fall,
   output logic sck
);
   localparam logic [7:0] DIV_END = 8'(CLK_DIV - 1);

   logic [7:0] div;
   logic       phase;
   logic       wrap;

   assign wrap = en && (div == DIV_END);
   assign rise = wrap && !phase;
   assign fall = wrap && phase;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div   <= '0;
         phase <= 1'b0;
         sck   <= 1'b0;
      end else if (!en) begin
         div   <= '0;
         phase <= 1'b0;
         sck   <= 1'b0;
      end else begin
         div <= wrap ? 8'd0 : div + 8'd1;
         if (wrap)
            phase <= !phase;
         if (rise)
            sck <= 1'b1;
         else if (fall)
            sck <= 1'b0;
      end
   end
endmodule

// File: rtl/spi_host_master.sv
// SPI mode-0 host master with nCS burst framing.
// Ports: clk, rst (async low), bus (word handshake), sck/mosi/miso/nCS.
module spi_host_master
   import spi_host_pkg::*;
#(
   parameter int WORD_W   = SPI_WORD_W,
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input  logic       clk,
   input  logic       rst,
   spi_host_if.slave  bus,
   output logic       sck,
   output logic       mosi,
   input  logic       miso,
   output logic       nCS
);
   localparam int BW = $clog2(WORD_W);
   localparam logic [BW-1:0] BIT_END = BW'(WORD_W - 1);
   localparam logic [15:0] CNT_SETUP = 16'(CS_SETUP - 1);
   localparam logic [15:0] CNT_RISE  = 16'(CS_HOLD - 1);
   localparam logic [15:0] CNT_DONE  = 16'(2 * CS_HOLD - 1);
   // With one-cycle half-periods the last delayed sample lands after
   // the final sck fall, so the word completes on that sample instead.
   localparam bit LATE = (CLK_DIV < 2);

   spi_host_state_t   state;
   logic [WORD_W-1:0] tx_sh;
   logic [WORD_W-1:0] rx_sh;
   logic [WORD_W-1:0] rx_next;
   logic [BW-1:0]     bit_cnt;
   logic [BW-1:0]     rx_cnt;
   logic [15:0]       cnt;
   logic              miso_q;
   logic              miso_s;
   logic [1:0]        samp_pipe;
   logic              rise;
   logic              fall;
   logic              samp;
   logic              bit_last;
   logic              rx_done;

   spi_host_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck (
      .clk  (clk),
      .rst  (rst),
      .en   (state == SHIFT),
      .rise (rise),
      .fall (fall),
      .sck  (sck)
   );

   // miso_s lags the pin by two cycles; sampling it two cycles after
   // the rise strobe sees the pin as it was at the sck rise.
   assign samp     = samp_pipe[1];
   assign rx_next  = {rx_sh[WORD_W-2:0], miso_s};
   assign bit_last = (bit_cnt == BIT_END);
   assign rx_done  = LATE ? (samp && rx_cnt == BIT_END)
                          : (fall && bit_last);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         miso_q      <= 1'b0;
         miso_s      <= 1'b0;
         samp_pipe   <= '0;
         rx_sh       <= '0;
         rx_cnt      <= '0;
         bus.rxData  <= '0;
         bus.rxValid <= 1'b0;
      end else begin
         miso_q      <= miso;
         miso_s      <= miso_q;
         samp_pipe   <= {samp_pipe[0], rise};
         bus.rxValid <= rx_done;
         if (samp) begin
            rx_sh  <= rx_next;
            rx_cnt <= (rx_cnt == BIT_END) ? '0 : rx_cnt + BW'(1);
         end
         if (rx_done)
            bus.rxData <= samp ? rx_next : rx_sh;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         nCS        <= 1'b1;
         mosi       <= 1'b0;
         bus.txDone <= 1'b0;
         bus.busy   <= 1'b0;
         tx_sh      <= '0;
         bit_cnt    <= '0;
         cnt        <= '0;
      end else begin
         bus.txDone <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.txRequest) begin
                  bus.txDone <= 1'b1;
                  bus.busy   <= 1'b1;
                  tx_sh      <= bus.txData;
                  mosi       <= bus.txData[WORD_W-1];
                  nCS        <= 1'b0;
                  cnt        <= '0;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == CNT_SETUP) begin
                  cnt   <= '0;
                  state <= SHIFT;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            SHIFT: begin
               if (fall) begin
                  if (bit_last) begin
                     bit_cnt <= '0;
                     state   <= NEXT;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                     tx_sh   <= {tx_sh[WORD_W-2:0], 1'b0};
                     mosi    <= tx_sh[WORD_W-2];
                  end
               end
            end
            NEXT: begin
               if (bus.txRequest) begin
                  bus.txDone <= 1'b1;
                  tx_sh      <= bus.txData;
                  mosi       <= bus.txData[WORD_W-1];
                  state      <= SHIFT;
               end else begin
                  // NEXT already counts as the first hold cycle.
                  cnt   <= 16'd1;
                  nCS   <= (CS_HOLD <= 1);
                  state <= HOLD;
               end
            end
            HOLD: begin
               cnt <= cnt + 16'd1;
               if (cnt >= CNT_RISE)
                  nCS <= 1'b1;
               if (cnt == CNT_DONE) begin
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_host_master.sv
// Bench for spi_host_master: loopback, burst, slave, reset, fast clock.
// Scoreboard queues hold expected rx words; monitors pop on rxValid.
`timescale 1ns/1ps
module tb_spi_host_master;
   import spi_host_pkg::*;

   localparam int W   = 16;
   localparam int D   = 4;
   localparam int CSS = 2;
   localparam int CSH = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   spi_host_if #(.WORD_W(W)) bus ();
   spi_host_if #(.WORD_W(W)) fbus ();

   logic sck, mosi, miso, ncs;
   logic fsck, fmosi, fncs;
   logic loop = 1'b1;
   logic slv_miso = 1'b1;

   assign miso = loop ? mosi : slv_miso;

   spi_host_master #(
      .WORD_W (W), .CLK_DIV (D), .CS_SETUP (CSS), .CS_HOLD (CSH)
   ) u_dut (
      .clk (clk), .rst (rst), .bus (bus),
      .sck (sck), .mosi (mosi), .miso (miso), .nCS (ncs)
   );

   spi_host_master #(
      .WORD_W (W), .CLK_DIV (1), .CS_SETUP (CSS), .CS_HOLD (CSH)
   ) u_fast (
      .clk (clk), .rst (rst), .bus (fbus),
      .sck (fsck), .mosi (fmosi), .miso (fmosi), .nCS (fncs)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   always @(posedge clk) cyc++;

   spi_word_t exp_q[$];
   spi_word_t fexp_q[$];

   int rises = 0, first_rise = -1, fall_cyc = 0;
   int ncs_falls = 0, ncs_rise_cyc = 0, ncs_hi_run = 0;
   int tds = 0, td_cyc = 0, td_gap = 0, rxvs = 0;
   logic sck_d = 1'b0, ncs_d = 1'b1, rxv_d = 1'b0;

   always @(posedge clk) begin
      #2;
      if (sck && !sck_d) begin
         rises++;
         if (first_rise < 0) first_rise = cyc;
      end
      if (!sck && sck_d) fall_cyc = cyc;
      if (!ncs && ncs_d) begin
         ncs_falls++;
         ncs_hi_run = cyc - ncs_rise_cyc;
      end
      if (ncs && !ncs_d) ncs_rise_cyc = cyc;
      if (bus.txDone) begin
         tds++;
         td_gap = cyc - td_cyc;
         td_cyc = cyc;
      end
      if (bus.rxValid) begin
         rxvs++;
         chk("rxv_pulse", rxv_d, 0);
         chk("rx_queue", exp_q.size() > 0, 1);
         if (exp_q.size() > 0)
            chk("rx_data", bus.rxData, exp_q.pop_front());
      end
      sck_d = sck;
      ncs_d = ncs;
      rxv_d = bus.rxValid;
   end

   int frises = 0, ffirst = -1, ffall = 0, frxvs = 0;
   logic fsck_d = 1'b0;

   always @(posedge clk) begin
      #2;
      if (fsck && !fsck_d) begin
         frises++;
         if (ffirst < 0) ffirst = cyc;
      end
      if (!fsck && fsck_d) ffall = cyc;
      if (fbus.rxValid) begin
         frxvs++;
         chk("f_rx_queue", fexp_q.size() > 0, 1);
         if (fexp_q.size() > 0)
            chk("f_rx_data", fbus.rxData, fexp_q.pop_front());
      end
      fsck_d = fsck;
   end

   // Mode-0 slave: MSB ready while nCS is high, next bit after each fall.
   logic [15:0] slv_word = 16'h1234;
   int   sidx = 0;
   logic ssck_p = 1'b0;

   always @(posedge clk) begin
      #1;
      if (ncs)
         sidx = 0;
      else if (ssck_p && !sck)
         sidx++;
      ssck_p = sck;
      slv_miso = (sidx < 16) ? slv_word[4'(15 - sidx)] : 1'b0;
   end

   task automatic wait_td(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.txDone && n < 400);
      chk("td_seen", bus.txDone, 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.busy && n < 2000);
      chk("idle", bus.busy, 0);
   endtask

   task automatic send(input spi_word_t d);
      bus.txData    = d;
      bus.txRequest = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int n, r0, v0, t0, c0;
      bus.txData     = '0;
      bus.txRequest  = 1'b0;
      fbus.txData    = '0;
      fbus.txRequest = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sck", sck, 0);
      chk("rst_ncs", ncs, 1);
      chk("rst_mosi", mosi, 0);
      chk("rst_txdone", bus.txDone, 0);
      chk("rst_rxvalid", bus.rxValid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_rxdata", bus.rxData, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // single word loopback
      r0 = rises; v0 = rxvs;
      send(16'hA55A);
      exp_q.push_back(16'hA55A);
      wait_td(n);
      chk("t1_td_lat", n, 1);
      bus.txRequest = 1'b0;
      wait_idle();
      chk("t1_sck", rises - r0, 16);
      chk("t1_rxv", rxvs - v0, 1);
      chk("t1_word", fall_cyc - first_rise + D, 2 * D * W);
      chk("t1_hold", ncs_rise_cyc - fall_cyc, CSH);
      repeat (2) @(negedge clk);

      // three-word burst
      r0 = rises; v0 = rxvs; t0 = tds; c0 = ncs_falls;
      send(16'h0001);
      exp_q.push_back(16'h0001);
      wait_td(n);
      send(16'h8000);
      exp_q.push_back(16'h8000);
      wait_td(n);
      send(16'hFFFF);
      exp_q.push_back(16'hFFFF);
      wait_td(n);
      bus.txRequest = 1'b0;
      wait_idle();
      chk("t2_ncs", ncs_falls - c0, 1);
      chk("t2_sck", rises - r0, 48);
      chk("t2_td", tds - t0, 3);
      chk("t2_rxv", rxvs - v0, 3);
      chk("t2_gap", td_gap, 2 * D * W + 1);
      repeat (2) @(negedge clk);

      // slave returns 1234 whatever mosi carries
      loop = 1'b0;
      v0 = rxvs;
      send(16'h5A5A);
      exp_q.push_back(16'h1234);
      wait_td(n);
      bus.txRequest = 1'b0;
      wait_idle();
      chk("t3_rxv", rxvs - v0, 1);
      loop = 1'b1;
      repeat (2) @(negedge clk);

      // reset after seven sck pulses
      r0 = rises; v0 = rxvs;
      send(16'hF00F);
      wait_td(n);
      bus.txRequest = 1'b0;
      n = 0;
      while (rises - r0 < 7 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t4_pulses", rises - r0, 7);
      rst = 1'b0;
      #1;
      chk("t4_ncs", ncs, 1);
      chk("t4_sck", sck, 0);
      chk("t4_busy", bus.busy, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("t4_norxv", rxvs - v0, 0);
      r0 = rises; c0 = ncs_falls;
      send(16'h3C5A);
      exp_q.push_back(16'h3C5A);
      wait_td(n);
      chk("t4_td_lat", n, 1);
      bus.txRequest = 1'b0;
      wait_idle();
      chk("t4_sck2", rises - r0, 16);
      chk("t4_rxv2", rxvs - v0, 1);
      chk("t4_ncs2", ncs_falls - c0, 1);
      repeat (2) @(negedge clk);

      // request raised during HOLD waits for IDLE
      c0 = ncs_falls;
      send(16'h1111);
      exp_q.push_back(16'h1111);
      wait_td(n);
      bus.txRequest = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.rxValid && n < 400);
      chk("t5_rxv_seen", bus.rxValid, 1);
      @(negedge clk);
      send(16'h2222);
      exp_q.push_back(16'h2222);
      wait_td(n);
      chk("t5_gap", ncs_hi_run >= CSH, 1);
      chk("t5_order", td_cyc > ncs_rise_cyc, 1);
      bus.txRequest = 1'b0;
      wait_idle();
      chk("t5_frames", ncs_falls - c0, 2);
      chk("t5_q_empty", exp_q.size(), 0);

      // CLK_DIV=1 loopback
      fbus.txData    = 16'hC3C3;
      fbus.txRequest = 1'b1;
      fexp_q.push_back(16'hC3C3);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!fbus.txDone && n < 20);
      chk("f_td_lat", n, 1);
      fbus.txRequest = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (fbus.busy && n < 200);
      chk("f_idle", fbus.busy, 0);
      chk("f_sck", frises, 16);
      chk("f_word", ffall - ffirst + 1, 2 * W);
      chk("f_rxv", frxvs, 1);
      chk("f_q_empty", fexp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/spi_host_master.md
Name: spi_host_master

Overview:
- Host-side SPI master that drives the SPI slave port of the dual-channel MIL-STD-1553/SPI bridge.
- Serialises 16-bit words from a push-style producer onto MOSI and captures MISO into 16-bit words for a consumer.
- Manages nCS framing: consecutive words form one burst frame under a single nCS assertion.
- Used by the host controller and as the bridge's bench-side driver.

Parameters:
- WORD_W, 16: bits per SPI word, MSB first.
- CLK_DIV, 4: clk cycles per SCK half-period; valid range 1..255.
- CS_SETUP, 2: clk cycles from nCS falling to the first SCK rise window start.
- CS_HOLD, 2: clk cycles from the last SCK fall to nCS rising; also the minimum nCS-high gap.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- txData  input  WORD_W  word to transmit
- txRequest  input  1  txData valid; held until txDone
- txDone  output  1  one-cycle pulse: txData captured into shifter
- rxData  output  WORD_W  last received word; held until next rxValid
- rxValid  output  1  one-cycle pulse: rxData updated
- busy  output  1  high in any state other than IDLE
- sck  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
- mosi  output  1  master out
- miso  input  1  master in; synchronised with two flops before sampling
- nCS  output  1  chip select, active low

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Outputs: sck=0, nCS=1, mosi=0, txDone=0, rxValid=0, busy=0, rxData=0.
  - Divider and bit counters are cleared.
- Reset mid-frame: the frame is aborted immediately with no rxValid and no further txDone. nCS rises asynchronously.
- State machine IDLE -> SETUP -> SHIFT -> (NEXT -> SHIFT)* -> HOLD -> IDLE.
- IDLE:
  - On txRequest=1: pulse txDone, load the shifter from txData, drive nCS=0 and mosi=txData[WORD_W-1] on the next cycle, then enter SETUP.
- SETUP: wait CS_SETUP cycles, then enter SHIFT with the divider at 0.
- SHIFT, each bit takes 2*CLK_DIV cycles:
  - After CLK_DIV cycles, sck rises and the synchronised miso is shifted into the rx shifter LSB.
  - After another CLK_DIV cycles, sck falls. If bits remain, mosi presents the next bit on that same cycle.
  - A bit counter counts 0..WORD_W-1.
  - Word time is 2*CLK_DIV*WORD_W clk cycles from SETUP exit to the last sck fall.
- End of word (the cycle of the last sck fall):
  - rxData is loaded and rxValid pulses on the next cycle.
  - Go to NEXT.
- NEXT:
  - If txRequest=1 in this cycle: pulse txDone, reload the tx shifter, present its MSB on mosi, and return to SHIFT with no SETUP delay. nCS stays low, so the words share one burst frame.
  - Otherwise go to HOLD.
- HOLD: nCS stays low for CS_HOLD cycles, then rises. Remain in HOLD for another CS_HOLD cycles with nCS=1, then go to IDLE. This guarantees the minimum gap.
- txRequest arriving during SETUP, SHIFT or HOLD is not accepted; it waits for NEXT or IDLE.
- txRequest deasserted without txDone is legal; nothing is sent.
- A word is always completed once started. A producer withdrawing txRequest never truncates a word.
- The rx and tx shifters are independent. rxData of word n appears at the same time txDone of word n+1 can occur.

Decomposition:
- Package spi_host_pkg holds:
  - typedef spi_word_t (logic [WORD_W-1:0]);
  - enum spi_host_state_t {IDLE, SETUP, SHIFT, NEXT, HOLD};
  - default constant SPI_WORD_W=16.
- Sub-module spi_host_sck_gen: CLK_DIV counter generating a rise-strobe and a fall-strobe plus sck. Enabled only in SHIFT; cleared on leaving SHIFT.
- The FSM, shifters and nCS timing stay in spi_host_master.

Test Plan:
- Single word, CLK_DIV=4, txData=16'hA55A, miso looped to mosi:
  - txDone at cycle 1 after the request.
  - 16 sck pulses, 128 cycles.
  - rxData=16'hA55A with a one-cycle rxValid.
  - nCS high again CS_HOLD cycles after the last fall.
- Burst of 3 words 16'h0001, 16'h8000, 16'hFFFF with txRequest held high:
  - Exactly one nCS low period.
  - 48 sck pulses.
  - Three txDone and three rxValid pulses.
  - No SETUP gap between words.
- miso driven from a bench slave returning 16'h1234 under mode 0: rxData=16'h1234 regardless of mosi content.
- Assert rst=0 after 7 sck pulses:
  - nCS=1, sck=0, busy=0 within the same cycle.
  - No rxValid.
  - A request after release starts a clean frame.
- CLK_DIV=1 and WORD_W=16: sck toggles every cycle, word time 32 cycles, correct 16'hC3C3 loopback.
- Two single-word frames back-to-back with txRequest reasserted during HOLD: the second txDone only after IDLE, with nCS high for at least CS_HOLD cycles.
